// File: rtl/rtp_pkg.sv
// Shared types for the RTP result path: collector state, buffered result record
// and the fixed field widths the record is built from.
package rtp_pkg;

   localparam int RTP_MAX_CH = 8;
   localparam int RTP_CH_W   = $clog2(RTP_MAX_CH);
   // Record fields are sized for the widest supported id / hitT (32 bits each).
   localparam int RTP_ID_W   = 32;
   localparam int RTP_T_W    = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } rtp_coll_state_e;

   typedef struct packed {
      logic [RTP_CH_W-1:0] ch;
      logic [RTP_ID_W-1:0] ray_id;
      logic [RTP_T_W-1:0]  hitT;
   } rtp_result_t;

endpackage

// File: rtl/rtp_sync_fifo.sv
// Single-clock result FIFO with synchronous flush; head is visible combinationally
// so a pushed entry appears on the read side one cycle after the push.
module rtp_sync_fifo
   import rtp_pkg::*;
#(
   parameter int WIDTH = $bits(rtp_result_t),
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO may still accept when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/rtp_result_collector.sv
// Round-robin collector of per-channel RTP results into one stream, with run-cycle
// and result counters. Define RTP_PERF_CNT_EN for per-channel push/stall counters.
module rtp_result_collector
   import rtp_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int ID_W       = 32,
   parameter int T_W        = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 64,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*ID_W-1:0]   in_ray_id,
   input  logic [NUM_CH*T_W-1:0]    in_hitT,
   input  logic [NUM_CH-1:0]        ch_finish,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ID_W-1:0]          out_ray_id,
   output logic [T_W-1:0]           out_hitT,
   output logic [CH_W-1:0]          out_ch,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         total_cycles,
   output logic [CNT_W-1:0]         result_count
`ifdef RTP_PERF_CNT_EN
   ,
   output logic [NUM_CH*CNT_W-1:0]  ch_result_count,
   output logic [NUM_CH*CNT_W-1:0]  ch_stall_count
`endif
);

   rtp_coll_state_e   state_q, state_d;
   logic [NUM_CH-1:0] mask_q, mask_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [CH_W-1:0]   grant_idx, cand;
   logic [NUM_CH-1:0] grant;
   logic              found;
   logic              active, push, out_hs, fifo_full, fifo_empty;
   rtp_result_t       push_data, head;
   logic [CNT_W-1:0]  total_q, total_d, count_q, count_d;
   logic              head_ch_unused;

   assign active = (state_q == RUN) || (state_q == DRAIN);

   // Arbiter is held off during start so nothing lands in the FIFO being flushed.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand      = '0;
      found     = 1'b0;
      push_data = '0;
      if (active && !fifo_full && !start) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (!found && in_valid[cand]) begin
               found       = 1'b1;
               grant[cand] = 1'b1;
               grant_idx   = cand;
            end
         end
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant[c]) begin
            push_data.ch     = RTP_CH_W'(c);
            push_data.ray_id = RTP_ID_W'(in_ray_id[c*ID_W +: ID_W]);
            push_data.hitT   = RTP_T_W'(in_hitT[c*T_W +: T_W]);
         end
      end
   end

   assign in_ready = grant;
   assign push     = found;
   assign ptr_d    = push ? CH_W'((int'(grant_idx) + 1) % NUM_CH) : ptr_q;

   rtp_sync_fifo #(
      .WIDTH ($bits(rtp_result_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .flush   (start),
      .push    (push),
      .wr_data (push_data),
      .pop     (out_ready),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign out_valid      = !fifo_empty;
   assign out_hs         = out_valid && out_ready;
   assign out_ray_id     = fifo_empty ? '0 : head.ray_id[ID_W-1:0];
   assign out_hitT       = fifo_empty ? '0 : head.hitT[T_W-1:0];
   assign out_ch         = fifo_empty ? '0 : head.ch[CH_W-1:0];
   assign head_ch_unused = ^head.ch;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN: begin
            mask_d = mask_q | ch_finish;
            if ((&mask_q) && !(|in_valid)) state_d = DRAIN;
         end
         DRAIN:   if (fifo_empty) state_d = DONE;
         DONE:    if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = RUN;
         mask_d  = '0;
      end
   end

   always_comb begin
      total_d = total_q;
      count_d = count_q;
      if (start) begin
         total_d = '0;
         count_d = '0;
      end else begin
         if (active && (total_q != '1)) total_d = total_q + 1'b1;
         if (out_hs && (count_q != '1)) count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mask_q  <= '0;
         ptr_q   <= '0;
         total_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         total_q <= total_d;
         count_q <= count_d;
      end
   end

   assign busy         = active;
   assign done         = (state_q == DONE);
   assign total_cycles = total_q;
   assign result_count = count_q;

`ifdef RTP_PERF_CNT_EN
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_perf
      logic [CNT_W-1:0] res_q, res_d, stall_q, stall_d;

      always_comb begin
         res_d   = res_q;
         stall_d = stall_q;
         if (start) begin
            res_d   = '0;
            stall_d = '0;
         end else if (active) begin
            if (grant[gi] && (res_q != '1)) res_d = res_q + 1'b1;
            if (in_valid[gi] && !grant[gi] && (stall_q != '1)) stall_d = stall_q + 1'b1;
         end
      end

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            res_q   <= '0;
            stall_q <= '0;
         end else begin
            res_q   <= res_d;
            stall_q <= stall_d;
         end
      end

      assign ch_result_count[gi*CNT_W +: CNT_W] = res_q;
      assign ch_stall_count[gi*CNT_W +: CNT_W]  = stall_q;
   end
`endif

endmodule

// File: tb/tb_rtp_result_collector.sv
// Scoreboard bench for rtp_result_collector (NUM_CH=2, FIFO_DEPTH=16).
module tb_rtp_result_collector;

   localparam int NUM_CH = 2;
   localparam int ID_W   = 32;
   localparam int T_W    = 32;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 64;

   logic                   clk;
   logic                   reset;
   logic                   start;
   logic [NUM_CH-1:0]      in_valid;
   logic [NUM_CH-1:0]      in_ready;
   logic [NUM_CH*ID_W-1:0] in_ray_id;
   logic [NUM_CH*T_W-1:0]  in_hitT;
   logic [NUM_CH-1:0]      ch_finish;
   logic                   out_valid;
   logic                   out_ready;
   logic [ID_W-1:0]        out_ray_id;
   logic [T_W-1:0]         out_hitT;
   logic [0:0]             out_ch;
   logic                   busy;
   logic                   done;
   logic [CNT_W-1:0]       total_cycles;
   logic [CNT_W-1:0]       result_count;
`ifdef RTP_PERF_CNT_EN
   logic [NUM_CH*CNT_W-1:0] ch_result_count;
   logic [NUM_CH*CNT_W-1:0] ch_stall_count;
`endif

   rtp_result_collector #(
      .NUM_CH     (NUM_CH),
      .ID_W       (ID_W),
      .T_W        (T_W),
      .FIFO_DEPTH (DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clock        (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_ray_id    (in_ray_id),
      .in_hitT      (in_hitT),
      .ch_finish    (ch_finish),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_ray_id   (out_ray_id),
      .out_hitT     (out_hitT),
      .out_ch       (out_ch),
      .busy         (busy),
      .done         (done),
      .total_cycles (total_cycles),
      .result_count (result_count)
`ifdef RTP_PERF_CNT_EN
      ,
      .ch_result_count (ch_result_count),
      .ch_stall_count  (ch_stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      logic [31:0] id;
      logic [31:0] t;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] src0[$];
   logic [31:0] src1[$];
   int          n_vec;
   int          n_err;
   int          busy_cycles;

   function automatic logic [31:0] hit_of(input logic [31:0] id);
      return (id << 8) ^ 32'h3F80_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic expect_res(input int ch, input logic [31:0] id);
      exp_t e;
      e.ch = ch;
      e.id = id;
      e.t  = hit_of(id);
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy_cycles = 0;
   endtask

   task automatic pulse_finish(input logic [NUM_CH-1:0] m);
      ch_finish = m;
      @(posedge clk); #1;
      ch_finish = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Presents each channel's queue head; advances a channel when its handshake lands.
   task automatic drive(input int ncyc, output int pushes);
      logic [NUM_CH-1:0] hs;
      pushes = 0;
      for (int n = 0; n < ncyc && (src0.size() != 0 || src1.size() != 0); n++) begin
         in_valid[0] = (src0.size() != 0);
         in_valid[1] = (src1.size() != 0);
         in_ray_id[31:0]  = in_valid[0] ? src0[0] : 32'd0;
         in_ray_id[63:32] = in_valid[1] ? src1[0] : 32'd0;
         in_hitT[31:0]    = hit_of(in_ray_id[31:0]);
         in_hitT[63:32]   = hit_of(in_ray_id[63:32]);
         @(negedge clk);
         hs = in_valid & in_ready;
         @(posedge clk); #1;
         if (hs[0]) begin src0.delete(0); pushes++; end
         if (hs[1]) begin src1.delete(0); pushes++; end
      end
      in_valid = '0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(name, sb.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int p;
      int n;
      logic [63:0] tc_hold;
      clk = 1'b0; reset = 1'b1; start = 1'b0; in_valid = '0; in_ray_id = '0;
      in_hitT = '0; ch_finish = '0; out_ready = 1'b0;
      n_vec = 0; n_err = 0; busy_cycles = 0;

      fork
         forever begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_out: got ch=%0d id=%0d, expected nothing", out_ch, out_ray_id);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  n_vec++;
                  if (out_ch !== 1'(e.ch) || out_ray_id !== e.id || out_hitT !== e.t) begin
                     n_err++;
                     $display("FAIL out_data: got ch=%0d id=%0d t=%h, expected ch=%0d id=%0d t=%h",
                              out_ch, out_ray_id, out_hitT, e.ch, e.id, e.t);
                  end else begin
                     $display("out ch=%0d id=%0d t=%h", out_ch, out_ray_id, out_hitT);
                  end
               end
            end
         end
      join_none

      // Reset state
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_total", total_cycles, 0);
      check("rst_count", result_count, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Interleaved streaming: 1,10,2,11,3
      out_ready = 1'b1;
      pulse_start();
      src0 = '{32'd1, 32'd2, 32'd3};
      src1 = '{32'd10, 32'd11};
      expect_res(0, 1); expect_res(1, 10); expect_res(0, 2); expect_res(1, 11); expect_res(0, 3);
      drive(20, p);
      check("t1_pushes", p, 5);
      wait_drain("t1_drain");
      check("t1_count", result_count, 5);
      check("t1_out_valid", out_valid, 0);
      check("t1_busy", busy, 1);

      // Fill to capacity with out_ready low, then drain in order
      apply_reset();
      out_ready = 1'b0;
      pulse_start();
      src0.delete(); src1.delete();
      for (int k = 0; k < 10; k++) begin
         src0.push_back(32'd100 + k);
         src1.push_back(32'd200 + k);
      end
      for (int k = 0; k < 8; k++) begin
         expect_res(0, 32'd100 + k);
         expect_res(1, 32'd200 + k);
      end
      drive(30, p);
      check("t2_pushes", p, 16);
      in_valid = 2'b11;
      in_ray_id = {32'd208, 32'd108};
      in_hitT = {hit_of(32'd208), hit_of(32'd108)};
      @(negedge clk);
      check("t2_full_in_ready", in_ready, 0);
      check("t2_head_id", out_ray_id, 100);
      @(posedge clk); #1;
      in_valid = '0;
      src0.delete(); src1.delete();
      out_ready = 1'b1;
      wait_drain("t2_drain");
      check("t2_count", result_count, 16);
      out_ready = 1'b0;

      // Finish with 4 queued -> DRAIN -> DONE
      apply_reset();
      pulse_start();
      src0 = '{32'd1, 32'd2};
      src1 = '{32'd3, 32'd4};
      expect_res(0, 1); expect_res(1, 3); expect_res(0, 2); expect_res(1, 4);
      drive(10, p);
      check("t3_pushes", p, 4);
      pulse_finish(2'b11);
      wait_cycles(2);
      check("t3_drain_busy", busy, 1);
      check("t3_drain_done", done, 0);
      check("t3_drain_valid", out_valid, 1);
      out_ready = 1'b1;
      n = 0;
      while (out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t3_fifo_empty", out_valid, 0);
      check("t3_done_not_yet", done, 0);
      @(negedge clk);
      check("t3_done_rise", done, 1);
      check("t3_total_cycles", total_cycles, 64'(busy_cycles));
      check("t3_count", result_count, 4);
      check("t3_sb_empty", sb.size(), 0);
      tc_hold = total_cycles;
      out_ready = 1'b0;
      @(posedge clk); #1;

      // Inputs in DONE are ignored
      src0.push_back(32'd99);
      drive(3, p);
      check("done_ignored_pushes", p, 0);
      check("done_out_valid", out_valid, 0);
      check("done_count_held", result_count, 4);
      check("done_total_held", total_cycles, tc_hold);
      src0.delete();

      // Restart in RUN with 5 queued
      apply_reset();
      pulse_start();
      src0 = '{32'd20, 32'd21, 32'd22};
      src1 = '{32'd30, 32'd31};
      drive(10, p);
      check("t4_pushes", p, 5);
      pulse_finish(2'b01);
      sb.delete();
      pulse_start();
      check("t4_out_valid", out_valid, 0);
      check("t4_total", total_cycles, 0);
      check("t4_count", result_count, 0);
      check("t4_busy", busy, 1);
      pulse_finish(2'b10);
      wait_cycles(5);
      check("t4_mask_cleared", done, 0);
      pulse_finish(2'b01);
      n = 0;
      while (!done && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      check("t4_done", done, 1);

      // Async reset in DRAIN
      apply_reset();
      pulse_start();
      src0 = '{32'd5, 32'd6};
      src1 = '{32'd7};
      expect_res(0, 5); expect_res(1, 7); expect_res(0, 6);
      drive(10, p);
      check("t5_pushes", p, 3);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t5_count", result_count, 1);
      pulse_finish(2'b11);
      wait_cycles(2);
      check("t5_busy", busy, 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_out_valid", out_valid, 0);
      check("t5_rst_total", total_cycles, 0);
      check("t5_rst_count", result_count, 0);
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b0;

`ifdef RTP_PERF_CNT_EN
      // Stall counting while full
      apply_reset();
      pulse_start();
      for (int k = 0; k < 16; k++) src1.push_back(32'd40 + k);
      drive(40, p);
      check("perf_fill", p, 16);
      src0.push_back(32'd77);
      drive(3, p);
      check("perf_full_pushes", p, 0);
      check("perf_stall0", ch_stall_count[0 +: CNT_W], 3);
      check("perf_stall1", ch_stall_count[CNT_W +: CNT_W], 0);
      check("perf_res1", ch_result_count[CNT_W +: CNT_W], 16);
      src0.delete();
      sb.delete();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
